// File: rtl/counter_display_pkg.sv
// Shared types and constants for the four-digit BCD counter and its scanned display.
// The leading-zero helper is used only when LEADING_ZERO_BLANK_EN is defined.
package counter_display_pkg;

  typedef logic [3:0] bcd_t;

  localparam int         NUM_DIGITS    = 4;
  localparam bcd_t       BCD_MAX       = 4'd9;
  localparam logic [3:0] ANODE_ALL_OFF = 4'b1111;
  localparam logic [3:0] ANODE_RESET   = 4'b1110;

  // True when digit idx and every digit above it are zero; digit 0 is never suppressed.
  function automatic logic leading_zero(input logic [15:0] cnt, input logic [1:0] idx);
    logic z;
    z = (idx != 2'd0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(idx)) && (cnt[4*j +: 4] != 4'd0)) z = 1'b0;
    end
    return z;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the counter: combinational increment/decrement with carry/borrow out.
// Chained four deep by the top so a whole-count step settles within one cycle.
module bcd_digit_step
  import counter_display_pkg::*;
(
  input  bcd_t d,
  input  logic inc,
  input  logic dec,
  output bcd_t d_next,
  output logic carry,
  output logic borrow
);

  always_comb begin
    d_next = d;
    carry  = 1'b0;
    borrow = 1'b0;
    if (inc) begin
      // >= rather than == keeps the digit inside 0..9 even from an illegal value
      if (d >= BCD_MAX) begin
        d_next = 4'd0;
        carry  = 1'b1;
      end else begin
        d_next = d + 4'd1;
      end
    end else if (dec) begin
      if (d == 4'd0) begin
        d_next = BCD_MAX;
        borrow = 1'b1;
      end else if (d > BCD_MAX) begin
        d_next = BCD_MAX;
      end else begin
        d_next = d - 4'd1;
      end
    end
  end

endmodule

// File: rtl/counter_display_ctrl.sv
// Up/down BCD counter sequencing (edge detect, arbitration, wrap pulses) and 7-seg digit scan.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits during the scan.
module counter_display_ctrl
  import counter_display_pkg::*;
#(
  parameter int SCAN_DIV   = 65536,
  parameter int SCAN_DIV_W = 16
) (
  input  logic        sysclock,
  input  logic        reset_n,
  input  logic        up_req,
  input  logic        down_req,
  input  logic        clear,
  output logic [15:0] count,
  output logic        wrap_up,
  output logic        wrap_down,
  output logic [3:0]  anode,
  output logic [3:0]  digit_bcd,
  output logic        blank
);

  logic up_prev, down_prev;
  logic up_edge, down_edge;
  logic step_up, step_down;

  logic [NUM_DIGITS:0] inc_chain, dec_chain;
  logic [15:0]         count_next;

  logic [SCAN_DIV_W-1:0] prescaler;
  logic [1:0]            scan_idx, scan_idx_next;
  logic                  scan_tc;
  logic                  blank_next;
  logic [3:0]            anode_next;

  assign up_edge   = up_req & ~up_prev;
  assign down_edge = down_req & ~down_prev;

  // Simultaneous edges cancel; clear overrides both.
  assign step_up   = ~clear & up_edge & ~down_edge;
  assign step_down = ~clear & down_edge & ~up_edge;

  assign inc_chain[0] = step_up;
  assign dec_chain[0] = step_down;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_step u_step (
      .d      (count[4*i +: 4]),
      .inc    (inc_chain[i]),
      .dec    (dec_chain[i]),
      .d_next (count_next[4*i +: 4]),
      .carry  (inc_chain[i+1]),
      .borrow (dec_chain[i+1])
    );
  end

  always_ff @(posedge sysclock or negedge reset_n) begin
    if (!reset_n) begin
      up_prev   <= 1'b0;
      down_prev <= 1'b0;
      count     <= 16'h0000;
      wrap_up   <= 1'b0;
      wrap_down <= 1'b0;
    end else begin
      up_prev   <= up_req;
      down_prev <= down_req;
      count     <= clear ? 16'h0000 : count_next;
      wrap_up   <= inc_chain[NUM_DIGITS];
      wrap_down <= dec_chain[NUM_DIGITS];
    end
  end

  assign scan_tc       = (prescaler == SCAN_DIV_W'(SCAN_DIV - 1));
  assign scan_idx_next = scan_tc ? scan_idx + 2'd1 : scan_idx;

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_next = leading_zero(count, scan_idx_next);
`else
  assign blank_next = 1'b0;
`endif

  assign anode_next = blank_next ? ANODE_ALL_OFF : ~(4'b0001 << scan_idx_next);

  always_ff @(posedge sysclock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      scan_idx  <= 2'd0;
      anode     <= ANODE_RESET;
      digit_bcd <= 4'd0;
      blank     <= 1'b0;
    end else begin
      prescaler <= scan_tc ? '0 : prescaler + 1'b1;
      scan_idx  <= scan_idx_next;
      anode     <= anode_next;
      digit_bcd <= count[{scan_idx_next, 2'b00} +: 4];
      blank     <= blank_next;
    end
  end

endmodule

// File: tb/tb_counter_display_ctrl.sv
// Directed bench for counter_display_ctrl with SCAN_DIV=4; inputs change and outputs are sampled on falling edges.
// Define LEADING_ZERO_BLANK_EN for both bench and RTL to exercise leading-zero blanking.
module tb_counter_display_ctrl;

  logic        sysclock;
  logic        reset_n;
  logic        up_req;
  logic        down_req;
  logic        clear;
  logic [15:0] count;
  logic        wrap_up;
  logic        wrap_down;
  logic [3:0]  anode;
  logic [3:0]  digit_bcd;
  logic        blank;

  int checks;
  int failures;
  int cyc;

  counter_display_ctrl #(
    .SCAN_DIV   (4),
    .SCAN_DIV_W (2)
  ) dut (
    .sysclock  (sysclock),
    .reset_n   (reset_n),
    .up_req    (up_req),
    .down_req  (down_req),
    .clear     (clear),
    .count     (count),
    .wrap_up   (wrap_up),
    .wrap_down (wrap_down),
    .anode     (anode),
    .digit_bcd (digit_bcd),
    .blank     (blank)
  );

  // clock / reset
  initial sysclock = 1'b0;
  always #5 sysclock = ~sysclock;

  // rising edges since the last reset release; scan index = (cyc/4)%4
  always @(posedge sysclock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // driver tasks
  task automatic pulse_up();
    @(negedge sysclock); up_req = 1'b1;
    @(negedge sysclock); up_req = 1'b0;
  endtask

  task automatic pulse_down();
    @(negedge sysclock); down_req = 1'b1;
    @(negedge sysclock); down_req = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge sysclock); clear = 1'b1;
    @(negedge sysclock); clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_anode [4];
    logic       exp_blank [4];
    int         idx;
`ifdef LEADING_ZERO_BLANK_EN
    exp_anode[0] = 4'b1110; exp_anode[1] = 4'b1111; exp_anode[2] = 4'b1111; exp_anode[3] = 4'b1111;
    exp_blank[0] = 1'b0;    exp_blank[1] = 1'b1;    exp_blank[2] = 1'b1;    exp_blank[3] = 1'b1;
`else
    exp_anode[0] = 4'b1110; exp_anode[1] = 4'b1101; exp_anode[2] = 4'b1011; exp_anode[3] = 4'b0111;
    exp_blank[0] = 1'b0;    exp_blank[1] = 1'b0;    exp_blank[2] = 1'b0;    exp_blank[3] = 1'b0;
`endif
    repeat (3) pulse_up();
    checks++;
    if (count !== 16'h0003) begin
      failures++; $display("FAIL pre_reset_count got %h exp %h", count, 16'h0003);
    end
    repeat (5) @(negedge sysclock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (count !== 16'h0000 || anode !== 4'b1110 || wrap_up !== 1'b0 || wrap_down !== 1'b0 ||
        digit_bcd !== 4'd0 || blank !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got count=%h anode=%b wu=%b wd=%b dig=%h blank=%b exp 0000 1110 0 0 0 0",
               count, anode, wrap_up, wrap_down, digit_bcd, blank);
    end
    @(negedge sysclock); reset_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge sysclock);
      idx = (k / 4) % 4;
      checks++;
      if (anode !== exp_anode[idx] || blank !== exp_blank[idx] || digit_bcd !== 4'd0) begin
        failures++;
        $display("FAIL scan_order k=%0d got anode=%b blank=%b dig=%h exp anode=%b blank=%b dig=0",
                 k, anode, blank, digit_bcd, exp_anode[idx], exp_blank[idx]);
      end
    end
  endtask

  task automatic test_hold();
    do_clear();
    repeat (9) pulse_up();
    checks++;
    if (count !== 16'h0009) begin
      failures++; $display("FAIL hold_start got %h exp %h", count, 16'h0009);
    end
    @(negedge sysclock); up_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclock);
      checks++;
      if (count !== 16'h0010) begin
        failures++; $display("FAIL hold_single_step cycle=%0d got %h exp %h", i, count, 16'h0010);
      end
    end
    up_req = 1'b0;
    @(negedge sysclock);
    checks++;
    if (count !== 16'h0010) begin
      failures++; $display("FAIL hold_release got %h exp %h", count, 16'h0010);
    end
  endtask

  task automatic test_wrap();
    do_clear();
    pulse_down();
    checks++;
    if (count !== 16'h9999 || wrap_down !== 1'b1 || wrap_up !== 1'b0) begin
      failures++; $display("FAIL wrap_down got count=%h wd=%b wu=%b exp 9999 1 0", count, wrap_down, wrap_up);
    end
    @(negedge sysclock);
    checks++;
    if (count !== 16'h9999 || wrap_down !== 1'b0) begin
      failures++; $display("FAIL wrap_down_width got count=%h wd=%b exp 9999 0", count, wrap_down);
    end
    pulse_up();
    checks++;
    if (count !== 16'h0000 || wrap_up !== 1'b1 || wrap_down !== 1'b0) begin
      failures++; $display("FAIL wrap_up got count=%h wu=%b wd=%b exp 0000 1 0", count, wrap_up, wrap_down);
    end
    @(negedge sysclock);
    checks++;
    if (count !== 16'h0000 || wrap_up !== 1'b0) begin
      failures++; $display("FAIL wrap_up_width got count=%h wu=%b exp 0000 0", count, wrap_up);
    end
  endtask

  task automatic test_borrow();
    do_clear();
    repeat (1000) pulse_up();
    checks++;
    if (count !== 16'h1000 || wrap_up !== 1'b0) begin
      failures++; $display("FAIL carry_to_1000 got count=%h wu=%b exp 1000 0", count, wrap_up);
    end
    pulse_down();
    checks++;
    if (count !== 16'h0999 || wrap_down !== 1'b0) begin
      failures++; $display("FAIL borrow_3_digits got count=%h wd=%b exp 0999 0", count, wrap_down);
    end
    pulse_up();
    checks++;
    if (count !== 16'h1000 || wrap_up !== 1'b0) begin
      failures++; $display("FAIL carry_3_digits got count=%h wu=%b exp 1000 0", count, wrap_up);
    end
  endtask

  task automatic test_conflict();
    do_clear();
    repeat (42) pulse_up();
    checks++;
    if (count !== 16'h0042) begin
      failures++; $display("FAIL conflict_start got %h exp %h", count, 16'h0042);
    end
    @(negedge sysclock); up_req = 1'b1; down_req = 1'b1;
    @(negedge sysclock);
    checks++;
    if (count !== 16'h0042 || wrap_up !== 1'b0 || wrap_down !== 1'b0) begin
      failures++; $display("FAIL conflict_drop got count=%h wu=%b wd=%b exp 0042 0 0", count, wrap_up, wrap_down);
    end
    up_req = 1'b0; down_req = 1'b0;
    @(negedge sysclock);
    checks++;
    if (count !== 16'h0042) begin
      failures++; $display("FAIL conflict_after got %h exp %h", count, 16'h0042);
    end
    clear = 1'b1; up_req = 1'b1;
    @(negedge sysclock);
    checks++;
    if (count !== 16'h0000 || wrap_up !== 1'b0 || wrap_down !== 1'b0) begin
      failures++; $display("FAIL clear_priority got count=%h wu=%b wd=%b exp 0000 0 0", count, wrap_up, wrap_down);
    end
    clear = 1'b0; up_req = 1'b0;
    @(negedge sysclock);
    checks++;
    if (count !== 16'h0000 || wrap_up !== 1'b0) begin
      failures++; $display("FAIL clear_after got count=%h wu=%b exp 0000 0", count, wrap_up);
    end
  endtask

  task automatic test_blank();
    logic [3:0] exp_anode [4];
    logic       exp_blank [4];
    logic [3:0] exp_dig   [4];
    int         idx;
`ifdef LEADING_ZERO_BLANK_EN
    exp_anode[0] = 4'b1110; exp_anode[1] = 4'b1101; exp_anode[2] = 4'b1111; exp_anode[3] = 4'b1111;
    exp_blank[0] = 1'b0;    exp_blank[1] = 1'b0;    exp_blank[2] = 1'b1;    exp_blank[3] = 1'b1;
`else
    exp_anode[0] = 4'b1110; exp_anode[1] = 4'b1101; exp_anode[2] = 4'b1011; exp_anode[3] = 4'b0111;
    exp_blank[0] = 1'b0;    exp_blank[1] = 1'b0;    exp_blank[2] = 1'b0;    exp_blank[3] = 1'b0;
`endif
    exp_dig[0] = 4'd0; exp_dig[1] = 4'd4; exp_dig[2] = 4'd0; exp_dig[3] = 4'd0;
    do_clear();
    repeat (40) pulse_up();
    @(negedge sysclock);
    checks++;
    if (count !== 16'h0040) begin
      failures++; $display("FAIL blank_count got %h exp %h", count, 16'h0040);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge sysclock);
      idx = (cyc / 4) % 4;
      checks++;
      if (anode !== exp_anode[idx] || blank !== exp_blank[idx] || digit_bcd !== exp_dig[idx]) begin
        failures++;
        $display("FAIL blank_scan idx=%0d got anode=%b blank=%b dig=%h exp anode=%b blank=%b dig=%h",
                 idx, anode, blank, digit_bcd, exp_anode[idx], exp_blank[idx], exp_dig[idx]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    up_req   = 1'b0;
    down_req = 1'b0;
    clear    = 1'b0;
    repeat (2) @(negedge sysclock);
    reset_n = 1'b1;

    test_reset();
    test_hold();
    test_wrap();
    test_borrow();
    test_conflict();
    test_blank();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
